// File: rtl/key_click_decoder.sv
// rtl/key_click_decoder.sv - classifies debounced key press bursts into single/double/triple clicks
//
// Purpose: counts key_flag press pulses that fall inside a sliding inter-press
// window and emits one classification pulse per burst.
//
// Ports:
//   sys_clk      in   system clock, rising edge
//   sys_rst      in   synchronous active-high reset
//   key_flag     in   one-cycle debounced press pulse
//   click_single out  one-cycle pulse, burst closed with 1 press
//   click_double out  one-cycle pulse, burst closed with 2 presses
//   click_triple out  one-cycle pulse, 3rd press of a burst seen
//   click_num    out  press count of the last classified burst, held
//   busy         out  high while a burst is open
module key_click_decoder #(
  parameter logic [23:0] CNT_WIN = 24'd14_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst,
  input  logic       key_flag,
  output logic       click_single,
  output logic       click_double,
  output logic       click_triple,
  output logic [1:0] click_num,
  output logic       busy
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]  state;
  logic [23:0] win_cnt;
  logic [1:0]  press_cnt;

  // busy is a decode of the state register, so it is registered as well.
  assign busy = (state == WAIT);

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= IDLE;
      win_cnt      <= 24'd0;
      press_cnt    <= 2'd0;
      click_single <= 1'b0;
      click_double <= 1'b0;
      click_triple <= 1'b0;
      click_num    <= 2'd0;
    end else begin
      click_single <= 1'b0;
      click_double <= 1'b0;
      click_triple <= 1'b0;
      case (state)
        IDLE: begin
          if (key_flag) begin
            press_cnt <= 2'd1;
            win_cnt   <= 24'd0;
            state     <= WAIT;
          end
        end
        WAIT: begin
          // A press takes priority over window expiry on the same edge.
          if (key_flag) begin
            if (press_cnt == 2'd1) begin
              press_cnt <= 2'd2;
              win_cnt   <= 24'd0;
            end else begin
              // Third press closes the burst at once.
              click_triple <= 1'b1;
              click_num    <= 2'd3;
              press_cnt    <= 2'd0;
              win_cnt      <= 24'd0;
              state        <= IDLE;
            end
          end else if (win_cnt == CNT_WIN) begin
            if (press_cnt == 2'd1) begin
              click_single <= 1'b1;
              click_num    <= 2'd1;
            end else if (press_cnt == 2'd2) begin
              click_double <= 1'b1;
              click_num    <= 2'd2;
            end
            press_cnt <= 2'd0;
            win_cnt   <= 24'd0;
            state     <= IDLE;
          end else begin
            win_cnt <= win_cnt + 24'd1;
          end
        end
        default: begin
          state     <= IDLE;
          press_cnt <= 2'd0;
          win_cnt   <= 24'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_key_click_decoder.sv
// tb/tb_key_click_decoder.sv - randomized and directed bench for key_click_decoder
module tb_key_click_decoder;

  localparam int WIN = 24;

  logic       sys_clk = 1'b0;
  logic       sys_rst = 1'b1;
  logic       key_flag = 1'b0;
  logic       click_single;
  logic       click_double;
  logic       click_triple;
  logic [1:0] click_num;
  logic       busy;

  int checks = 0;
  int passed = 0;

  key_click_decoder #(.CNT_WIN(24'd24)) dut (
    .sys_clk      (sys_clk),
    .sys_rst      (sys_rst),
    .key_flag     (key_flag),
    .click_single (click_single),
    .click_double (click_double),
    .click_triple (click_triple),
    .click_num    (click_num),
    .busy         (busy)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference model: a burst is an open list of press times; it closes when
  // a third press arrives or when WIN+1 edges pass since its last press.
  int   t = 0;
  bit   m_open = 0;
  int   m_cnt = 0;
  int   m_last = 0;
  bit   e_s = 0, e_d = 0, e_t = 0;
  logic [1:0] e_num = 2'd0;
  bit   m_valid = 0;

  always @(posedge sys_clk) begin
    t = t + 1;
    e_s = 0; e_d = 0; e_t = 0;
    if (sys_rst) begin
      m_open = 0; m_cnt = 0; e_num = 2'd0; m_valid = 1;
    end else if (key_flag) begin
      if (!m_open) begin
        m_open = 1; m_cnt = 1; m_last = t;
      end else if (m_cnt == 1) begin
        m_cnt = 2; m_last = t;
      end else begin
        e_t = 1; e_num = 2'd3; m_open = 0; m_cnt = 0;
      end
    end else if (m_open && (t - m_last) == WIN + 1) begin
      if (m_cnt == 1) begin
        e_s = 1; e_num = 2'd1;
      end else begin
        e_d = 1; e_num = 2'd2;
      end
      m_open = 0; m_cnt = 0;
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge sys_clk) begin
    if (m_valid) begin
      checks = checks + 1;
      if ({click_single, click_double, click_triple, click_num, busy} ===
          {e_s, e_d, e_t, e_num, m_open})
        passed = passed + 1;
      else
        $display("FAIL cycle_model t=%0d got s/d/t/num/busy=%b%b%b/%0d/%b expected %b%b%b/%0d/%b",
                 t, click_single, click_double, click_triple, click_num, busy,
                 e_s, e_d, e_t, e_num, m_open);
    end
  end

  task automatic tick(input logic f, input logic r);
    key_flag = f;
    sys_rst  = r;
    @(posedge sys_clk);
    #1;
    key_flag = 1'b0;
    sys_rst  = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) tick(1'b0, 1'b0);
  endtask

  // Hand-computed literal expectation: {single,double,triple,num,busy}.
  task automatic lit(input string name, input logic [5:0] exp);
    logic [5:0] act;
    act = {click_single, click_double, click_triple, click_num, busy};
    checks = checks + 1;
    if (act === exp) passed = passed + 1;
    else $display("FAIL %s got %b expected %b", name, act, exp);
  endtask

  initial begin
    int gap;
    int sel;
    // Reset then idle
    tick(1'b0, 1'b1);
    tick(1'b0, 1'b1);
    lit("reset_state", 6'b000_00_0);
    idle(100);
    lit("idle_100", 6'b000_00_0);

    // Single press: flag at E
    tick(1'b1, 1'b0);
    lit("single_busy_rise", 6'b000_00_1);
    idle(24);
    lit("single_E24", 6'b000_00_1);
    idle(1);
    lit("single_E25", 6'b100_01_0);
    idle(1);
    lit("single_after", 6'b000_01_0);
    idle(5);

    // Double press: E, E+10
    tick(1'b1, 1'b0);
    idle(9);
    tick(1'b1, 1'b0);
    idle(24);
    lit("double_E34", 6'b000_01_1);
    idle(1);
    lit("double_E35", 6'b010_10_0);
    idle(5);

    // Triple press: E, E+5, E+10
    tick(1'b1, 1'b0);
    idle(4);
    tick(1'b1, 1'b0);
    idle(4);
    tick(1'b1, 1'b0);
    lit("triple_E10", 6'b001_11_0);
    idle(40);
    lit("triple_no_expiry", 6'b000_11_0);

    // Boundary: E, E+25 -> double after E+50
    tick(1'b1, 1'b0);
    idle(24);
    tick(1'b1, 1'b0);
    lit("bound25_no_single", 6'b000_11_1);
    idle(24);
    tick(1'b0, 1'b0);
    lit("bound25_double_E50", 6'b010_10_0);
    idle(5);

    // Boundary: E, E+26 -> single after E+25, new burst, single after E+51
    tick(1'b1, 1'b0);
    idle(24);
    tick(1'b0, 1'b0);
    lit("bound26_single_E25", 6'b100_01_0);
    tick(1'b1, 1'b0);
    lit("bound26_new_burst", 6'b000_01_1);
    idle(24);
    tick(1'b0, 1'b0);
    lit("bound26_single_E51", 6'b100_01_0);
    idle(5);

    // Reset mid-burst
    tick(1'b0, 1'b1);
    tick(1'b1, 1'b0);
    idle(11);
    tick(1'b0, 1'b1);
    lit("reset_mid_burst", 6'b000_00_0);
    idle(40);
    lit("reset_no_pulse", 6'b000_00_0);

    // Randomized bursts with gaps around the window edge
    repeat (200) begin
      sel = $urandom_range(0, 3);
      case (sel)
        0: gap = $urandom_range(2, 10);
        1: gap = $urandom_range(22, 28);
        2: gap = $urandom_range(29, 60);
        default: gap = 2;
      endcase
      repeat (gap - 1) tick(1'b0, ($urandom_range(0, 299) == 0) ? 1'b1 : 1'b0);
      tick(1'b1, 1'b0);
    end
    idle(60);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/key_click_decoder.md
# key_click_decoder

Downstream consumer of the key debounce stage. Takes the debounced one-cycle `key_flag` press pulse and classifies bursts of presses into single, double or triple clicks using an inter-press time window. It emits one classification pulse per burst. Its outputs drive mode-select logic such as LED pattern or counter control.

## Interface
- `CNT_WIN`, default 24'd14_999_999: last index of the inter-press window counter. The window is CNT_WIN+1 clock cycles, which is 300 ms at 50 MHz. The bench uses 24'd24.
- `sys_clk`  in  1  system clock; all logic on rising edge.
- `sys_rst`  in  1  synchronous, active-high reset.
- `key_flag`  in  1  one-cycle pulse per debounced press, from the debounce stage. Consecutive flags are at least 2 cycles apart.
- `click_single`  out  1  one-cycle pulse: burst ended with exactly 1 press.
- `click_double`  out  1  one-cycle pulse: burst ended with exactly 2 presses.
- `click_triple`  out  1  one-cycle pulse: 3rd press of a burst detected.
- `click_num`  out  2  press count of the most recent classified burst (1..3). Updated with each click pulse and held otherwise.
- `busy`  out  1  high while a burst is open, i.e. state WAIT.

## Operation
- Two-state FSM: IDLE and WAIT. Internal `win_cnt` is 24 bits. Internal `press_cnt` is 2 bits.
- All outputs are registered.
- Reset values: state IDLE, `win_cnt`=0, `press_cnt`=0, all pulses 0, `click_num`=0, `busy`=0.
- IDLE, `key_flag`=1:
  - `press_cnt`←1, `win_cnt`←0, go to WAIT.
- IDLE, no flag: hold.
- WAIT, `key_flag`=1 and `press_cnt`=1:
  - `press_cnt`←2, `win_cnt`←0, stay in WAIT.
- WAIT, `key_flag`=1 and `press_cnt`=2:
  - `click_triple`←1, `click_num`←3, `press_cnt`←0, go to IDLE. The triple is reported immediately, without waiting for the window.
- WAIT, no flag, `win_cnt`==CNT_WIN:
  - If `press_cnt`=1: `click_single`←1, `click_num`←1.
  - If `press_cnt`=2: `click_double`←1, `click_num`←2.
  - Then `press_cnt`←0, `win_cnt`←0, go to IDLE.
- WAIT, otherwise: `win_cnt`←`win_cnt`+1.
- Simultaneous `key_flag` and `win_cnt`==CNT_WIN: the flag wins. The press is counted, the window restarts, and no expiry pulse is emitted.
- At most one of `click_single`, `click_double`, `click_triple` is high in any cycle. Each pulse is exactly one cycle wide.
- A flag arriving in IDLE in the same cycle a pulse is high starts a new burst normally.
- `win_cnt` never exceeds CNT_WIN. No wrap-around is possible.
- Reset asserted mid-burst: the burst is discarded, no pulse is emitted, and all state returns to reset values at that edge.

## Timing
- Edge E is the edge that samples the last press of a burst.
- `busy` rises on the edge that samples the first flag of a burst.
- `busy` falls on the same edge a click pulse rises.
- Single or double result:
  - The pulse and the `click_num` update are set at edge E+CNT_WIN+1.
  - The pulse is high for the one cycle following that edge.
- Triple result:
  - The pulse and `click_num`=3 are set at edge E itself, which is 1-cycle latency from the flag.
- A second press extends the burst only if its flag is sampled at edge E+1 through E+CNT_WIN+1 inclusive. The inclusive upper bound covers the simultaneous-event rule.
- Throughput: one classification per burst. No back-pressure. The outputs have no handshake.

## Test plan
All cases use CNT_WIN=24.
- Reset then idle: hold `sys_rst`=1 for 2 cycles, then run 100 idle cycles → all outputs 0 throughout.
- Single press: one flag sampled at edge E → `click_single`=1 only in the cycle after edge E+25, `click_num`=1, `busy` high from E to E+25. No other pulses.
- Double press: flags at E and E+10 → `click_double` pulse after edge E+35, `click_num`=2. No single pulse.
- Triple press: flags at E, E+5, E+10 → `click_triple` pulse after edge E+10, `click_num`=3, `busy` low after E+10. No pulse at window expiry.
- Boundary: flags at E and exactly E+25 → counted as double and the window restarts. The result is `click_double` after E+50, with no `click_single` at E+25. Flags at E and E+26 → `click_single` after E+25, then a new burst; a further `click_single` follows after E+51.
- Reset mid-burst: flag at E, `sys_rst` pulsed at E+12 → no click pulse ever appears for that burst, `busy`=0 after E+12, `click_num` retains 0 from reset.
